// File: rtl/dvi_frame_fetch_if.sv
// dvi_frame_fetch_if: frame-buffer read port between the scan-out fetcher and memory
interface dvi_frame_fetch_if;
   logic        valid;
   logic        rw;
   logic [27:0] addr;
   logic [31:0] data_rd;
   logic        ready;
   modport master (output valid, rw, addr, input data_rd, ready);
   modport slave (input valid, rw, addr, output data_rd, ready);
endinterface

// File: rtl/dvi_frame_fetch.sv
// dvi_frame_fetch: VGA/DVI timing generator that fetches frame-buffer words into a pixel FIFO
// and presents one 24-bit pixel per active pixel_en strobe.
module dvi_frame_fetch #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [27:0]       mem_start,
   input  logic              display_on,
   input  logic              pixel_en,
   dvi_frame_fetch_if.master fb_mem,
   output logic              dvi_hsync,
   output logic              dvi_vsync,
   output logic              dvi_de,
   output logic [23:0]       dvi_rgb,
   output logic              underflow
);
   localparam int HT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW   = $clog2(HT);
   localparam int VW   = $clog2(VT);
   localparam int NPIX = H_ACTIVE * V_ACTIVE;
   localparam int CW   = $clog2(NPIX + 1);
   localparam int AW   = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t        state;
   logic [HW-1:0] h;
   logic [VW-1:0] v;
   logic [27:0]   ptr;
   logic          en;
   logic [CW-1:0] fcnt;
   logic [23:0]   fifo [FIFO_DEPTH];
   logic [AW-1:0] rd, wr;
   logic [AW:0]   cnt;
   logic          h_last, active, frame, push, pop, can_req;

   assign h_last  = h == HW'(HT - 1);
   assign active  = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
   assign frame   = pixel_en && v == VW'(V_ACTIVE) && h == '0;
   assign pop     = pixel_en && active && en && cnt != '0;
   assign push    = fb_mem.ready && state == REQ && !frame;
   assign can_req = en && !frame && fcnt < CW'(NPIX) && cnt < (AW+1)'(FIFO_DEPTH);
   assign fb_mem.rw = 1'b0;

   always_ff @(posedge clk)
      if (rst) begin
         h         <= '0;
         v         <= '0;
         dvi_hsync <= 1'b1;
         dvi_vsync <= 1'b1;
         dvi_de    <= 1'b0;
         dvi_rgb   <= '0;
         underflow <= 1'b0;
      end else if (pixel_en) begin
         h         <= h_last ? '0 : h + 1'b1;
         if (h_last) v <= (v == VW'(VT - 1)) ? '0 : v + 1'b1;
         dvi_hsync <= !(h >= HW'(H_ACTIVE + H_FP) && h < HW'(H_ACTIVE + H_FP + H_SYNC));
         dvi_vsync <= !(v >= VW'(V_ACTIVE + V_FP) && v < VW'(V_ACTIVE + V_FP + V_SYNC));
         dvi_de    <= active;
         dvi_rgb   <= pop ? fifo[rd] : '0;
         underflow <= frame ? 1'b0 : (underflow || (active && en && cnt == '0));
      end

   // a request caught by the frame boundary is completed in DISCARD and its data dropped
   always_ff @(posedge clk)
      if (rst) begin
         state        <= IDLE;
         fb_mem.valid <= 1'b0;
         fb_mem.addr  <= '0;
         en           <= 1'b0;
         ptr          <= '0;
         fcnt         <= '0;
         rd           <= '0;
         wr           <= '0;
         cnt          <= '0;
      end else begin
         if (frame) begin
            en   <= display_on;
            ptr  <= mem_start;
            fcnt <= '0;
            rd   <= '0;
            wr   <= '0;
            cnt  <= '0;
         end else begin
            if (push) begin
               ptr  <= ptr + 28'd1;
               fcnt <= fcnt + 1'b1;
               wr   <= wr + 1'b1;
            end
            if (pop) rd <= rd + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         end
         case (state)
            IDLE: if (can_req) begin
               state        <= REQ;
               fb_mem.valid <= 1'b1;
               fb_mem.addr  <= ptr;
            end
            default: if (fb_mem.ready) begin
               state        <= IDLE;
               fb_mem.valid <= 1'b0;
            end else if (frame) state <= DISCARD;
         endcase
      end

   always_ff @(posedge clk)
      if (push) fifo[wr] <= fb_mem.data_rd[23:0];
endmodule

// File: tb/tb_dvi_frame_fetch.sv
// tb_dvi_frame_fetch: directed bench with a timing model, a pixel/address scoreboard
// and a memory responder with programmable latency and hold-off.
module tb_dvi_frame_fetch;
   logic        clk = 1'b0;
   logic        rst, display_on, pixel_en;
   logic [27:0] mem_start;
   logic        dvi_hsync, dvi_vsync, dvi_de, underflow;
   logic [23:0] dvi_rgb;

   dvi_frame_fetch_if fb_mem ();

   dvi_frame_fetch #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .mem_start(mem_start), .display_on(display_on),
      .pixel_en(pixel_en), .fb_mem(fb_mem), .dvi_hsync(dvi_hsync), .dvi_vsync(dvi_vsync),
      .dvi_de(dvi_de), .dvi_rgb(dvi_rgb), .underflow(underflow)
   );

   always #5 clk = ~clk;

   int          errors = 0, checks = 0;
   int          mh = 0, mv = 0, cyc = 0, cad = 1, pix = 0, lat = 1;
   int          nreq = 0, starve = 0, de_cnt = 0, wcnt = 0, n0 = 0;
   bit          en_m = 1'b0, hold = 1'b0, strict = 1'b1, busy = 1'b0;
   logic [27:0] req_addr;
   logic [23:0] exp_pix [$];
   logic [27:0] exp_addr [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock; model the pixel just produced and refill the scoreboard at a frame boundary
   task automatic step();
      bit          pe, r, d, act;
      logic [27:0] ms;
      pe = pixel_en;
      r  = rst;
      d  = display_on;
      ms = mem_start;
      @(posedge clk);
      #1;
      if (r) begin
         mh = 0;
         mv = 0;
         en_m = 1'b0;
         exp_pix.delete();
         exp_addr.delete();
      end else if (pe) begin
         pix++;
         act = mh < 4 && mv < 2;
         chk("hsync", 32'(dvi_hsync), 32'(!(mh == 5 || mh == 6)));
         chk("vsync", 32'(dvi_vsync), 32'(mv != 3));
         chk("de", 32'(dvi_de), 32'(act));
         if (dvi_de) de_cnt++;
         if (!act || !en_m) chk("rgb_blank", 32'(dvi_rgb), 32'(0));
         else if (!strict && dvi_rgb == 24'h0) begin
            starve++;
            chk("uf_set", 32'(underflow), 32'(1));
         end else if (exp_pix.size() == 0) chk("pix_extra", 32'(dvi_rgb), 32'(0));
         else chk("pixel", 32'(dvi_rgb), 32'(exp_pix.pop_front()));
         if (mv == 2 && mh == 0) begin
            en_m = d;
            exp_pix.delete();
            exp_addr.delete();
            if (d) for (int i = 0; i < 8; i++) begin
               exp_addr.push_back(ms + 28'(i));
               exp_pix.push_back(24'(ms + 28'(i)));
            end
            chk("uf_clear", 32'(underflow), 32'(0));
         end
         if (mh == 7) begin
            mh = 0;
            mv = (mv == 4) ? 0 : mv + 1;
         end else mh++;
      end
      cyc++;
      pixel_en = (cyc % cad) == 0;
   endtask

   task automatic run_pix(input int n);
      int target;
      target = pix + n;
      while (pix < target) step();
   endtask

   // memory: answers each request after lat cycles with data = address, one-cycle ready
   initial forever begin
      @(negedge clk);
      if (rst) begin
         fb_mem.ready = 1'b0;
         busy = 1'b0;
      end else if (fb_mem.ready) begin
         fb_mem.ready = 1'b0;
         busy = 1'b0;
         chk("valid_drop", 32'(fb_mem.valid), 32'(0));
      end else if (fb_mem.valid) begin
         if (!busy) begin
            busy = 1'b1;
            wcnt = 0;
            nreq++;
            req_addr = fb_mem.addr;
            chk("rw", 32'(fb_mem.rw), 32'(0));
            if (exp_addr.size() != 0) chk("req_addr", 32'(fb_mem.addr), 32'(exp_addr.pop_front()));
         end else chk("addr_hold", 32'(fb_mem.addr), 32'(req_addr));
         if (!hold) begin
            wcnt++;
            if (wcnt >= lat) begin
               fb_mem.ready = 1'b1;
               fb_mem.data_rd = {4'h0, fb_mem.addr};
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      pixel_en = 1'b1;
      display_on = 1'b0;
      mem_start = '0;
      fb_mem.ready = 1'b0;
      fb_mem.data_rd = '0;
      repeat (3) step();
      chk("rst_hsync", 32'(dvi_hsync), 32'(1));
      chk("rst_vsync", 32'(dvi_vsync), 32'(1));
      chk("rst_de", 32'(dvi_de), 32'(0));
      chk("rst_rgb", 32'(dvi_rgb), 32'(0));
      chk("rst_valid", 32'(fb_mem.valid), 32'(0));
      chk("rst_addr", 32'(fb_mem.addr), 32'(0));
      chk("rst_uf", 32'(underflow), 32'(0));
      // timing with display off, pixel_en every clock
      rst = 1'b0;
      de_cnt = 0;
      run_pix(40);
      chk("de_per_frame", 32'(de_cnt), 32'(8));
      run_pix(40);
      chk("req_display_off", 32'(nreq), 32'(0));
      // fetch order; settings change mid-frame and wait for the boundary
      display_on = 1'b1;
      mem_start = 28'h0000100;
      cad = 2;
      run_pix(10);
      chk("midframe_no_effect", 32'(nreq), 32'(0));
      run_pix(46);
      chk("fetch_pix_left", 32'(exp_pix.size()), 32'(0));
      chk("fetch_req_cnt", 32'(nreq), 32'(8));
      chk("fetch_uf", 32'(underflow), 32'(0));
      // underflow with slow memory
      lat = 20;
      cad = 1;
      mem_start = 28'h0000200;
      strict = 1'b0;
      starve = 0;
      run_pix(40);
      chk("uf_sticky", 32'(underflow), 32'(1));
      chk("starved_pixels", 32'(starve > 0), 32'(1));
      lat = 1;
      cad = 2;
      run_pix(1);
      chk("uf_cleared", 32'(underflow), 32'(0));
      // frame boundary while a read is held off
      run_pix(4);
      hold = 1'b1;
      mem_start = 28'h0000300;
      run_pix(38);
      chk("valid_held", 32'(fb_mem.valid), 32'(1));
      hold = 1'b0;
      strict = 1'b1;
      run_pix(37);
      chk("newbase_pix_left", 32'(exp_pix.size()), 32'(0));
      chk("newbase_uf", 32'(underflow), 32'(0));
      // reset with a request outstanding
      hold = 1'b1;
      for (int i = 0; i < 200 && fb_mem.valid !== 1'b1; i++) step();
      chk("valid_before_rst", 32'(fb_mem.valid), 32'(1));
      rst = 1'b1;
      step();
      chk("rst2_valid", 32'(fb_mem.valid), 32'(0));
      chk("rst2_hsync", 32'(dvi_hsync), 32'(1));
      chk("rst2_vsync", 32'(dvi_vsync), 32'(1));
      chk("rst2_de", 32'(dvi_de), 32'(0));
      chk("rst2_rgb", 32'(dvi_rgb), 32'(0));
      chk("rst2_uf", 32'(underflow), 32'(0));
      rst = 1'b0;
      hold = 1'b0;
      n0 = nreq;
      run_pix(16);
      chk("rst2_blank_frame", 32'(nreq), 32'(n0));
      run_pix(40);
      chk("rst2_pix_left", 32'(exp_pix.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/dvi_frame_fetch.md
Name: dvi_frame_fetch

Overview:
- Display scan-out stage directly downstream of the IO address map block.
- Consumes the frame-buffer base register (mem_start) and display_on from the IO map, generates VGA/DVI timing, and fetches pixel words from memory over the valid/ready memory handshake.
- Buffers fetched words in a small FIFO and presents one 24-bit RGB pixel per pixel_en strobe to the DVI encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, ≥4)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- mem_start  in  28  frame-buffer base word address, from the IO map block
- display_on  in  1  display enable, from the IO map block
- pixel_en  in  1  one-cycle pixel-clock strobe; timing advances only when it is high
- fb_mem_valid  out  1  read request valid
- fb_mem_rw  out  1  always 0 (read only)
- fb_mem_addr  out  28  word address of the request
- fb_mem_data_rd  in  32  read data, valid while fb_mem_ready=1
- fb_mem_ready  in  1  one-cycle response strobe
- dvi_hsync  out  1  horizontal sync, active low
- dvi_vsync  out  1  vertical sync, active low
- dvi_de  out  1  data enable (active region)
- dvi_rgb  out  24  pixel colour; word bits [23:0]
- underflow  out  1  sticky FIFO-underflow flag, cleared at frame boundary

Behaviour:
- Reset values:
  - hsync=1, vsync=1, de=0, rgb=0, fb_mem_valid=0, fb_mem_addr=0, underflow=0.
  - h/v counters = 0; FIFO empty; frame enable latch = 0.
  - Result: the first frame after reset is blank.
- Timing counters:
  - h counts 0..H_TOTAL-1 (H_TOTAL = sum of horizontal params); v counts 0..V_TOTAL-1.
  - Both advance only on pixel_en. h wraps and increments v; v wraps to 0.
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - hsync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v.
- Outputs are registered: hsync/vsync/de/rgb reflect the counter state of the same pixel_en cycle, visible the next clk, and hold between strobes.
- Frame boundary: the pixel_en cycle with v==V_ACTIVE, h==0. On that cycle:
  - latch base=mem_start and en=display_on;
  - reset fetch pointer to base and fetch count to 0;
  - flush FIFO; clear underflow.
- Fetch engine, FSM IDLE/REQ/DISCARD:
  - IDLE→REQ when en && fetch count < H_ACTIVE*V_ACTIVE && FIFO free slots > 0 (counting the outstanding request). Drive valid=1, rw=0, addr=pointer.
  - REQ: hold valid/addr stable until ready=1. On ready: push data into the FIFO, pointer+1, count+1, drop valid the next cycle, return to IDLE.
  - Exactly one request is outstanding at a time. Valid is never reasserted in the cycle ready is seen, because the memory toggles ready.
  - Frame boundary while in REQ → go to DISCARD. The response is consumed, not pushed, then go to IDLE.
- Pixel pop:
  - On a pixel_en cycle with active && en && FIFO non-empty: pop the FIFO and output word[23:0], de=1.
  - FIFO empty in that case: rgb=0, de=1, no pop, underflow←1.
  - en=0: de follows active, rgb=0, FIFO untouched.
- Simultaneous events:
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Flush beats push on a frame boundary.
- Address arithmetic is 28-bit modulo; it wraps past 28'hFFFFFFF to 0.
- display_on or mem_start changes mid-frame take effect only at the next frame boundary.

Test Plan:
- Timing check. Small params H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, pixel_en=1 constantly. Required: hsync low exactly at h=5,6 each line; vsync low exactly on line v=3; de high for 8 pixels per frame.
- Fetch order. Set mem_start=28'h0000100, display_on=1, memory returns data=address, ready 1 cycle after valid. Required: in the frame after the boundary, reads go to addresses 0x100..0x107 in order, with valid dropping between transactions. Pixels are 0x000100..0x000107 with de=1.
- Display off. Set display_on=0 at the boundary. Required: no fb_mem_valid for the whole frame; rgb=0; syncs unchanged.
- Underflow. Memory ready delayed 20 cycles, FIFO_DEPTH=4. Required: underflow=1 with rgb=0 on starved pixels; underflow clears at the next boundary.
- Boundary during a read. Hold ready off across the frame boundary, then pulse it. Required: the response is not pushed; the new frame's first read uses the newly latched base.
- Reset during fetch. Assert rst with valid=1. Required: next clk has valid=0, hsync=1, de=0, counters at 0.
